// File: rtl/dma_req_arbiter.sv
// Four-channel DMA request arbiter: latches request rising edges as pending bits and offers
// one channel at a time to the DMA engine over a valid/ready grant, held until transfer done.
module dma_req_arbiter #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic              ACLK_i,
    input  logic              axi_m_rst_i,
    input  logic              SYNC_P0_REQ_i,
    input  logic              SYNC_P1_REQ_i,
    input  logic              SYNC_P2_REQ_i,
    input  logic              SYNC_P3_REQ_i,
    input  logic [NUM_CH-1:0] reg_ch_en_i,
    input  logic              reg_prio_mode_i,
    output logic              arb_grant_valid_o,
    output logic [1:0]        arb_grant_ch_o,
    input  logic              arb_grant_ready_i,
    input  logic              arb_xfer_done_i,
    output logic              arb_busy_o,
    output logic [NUM_CH-1:0] arb_pend_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]        r_state;
    logic [NUM_CH-1:0] r_req_d;
    logic [NUM_CH-1:0] r_pend;
    logic [1:0]        r_rr_ptr;
    logic [1:0]        r_grant_ch;
    logic              r_grant_valid;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_active_mask;
    logic [NUM_CH-1:0] w_done_mask;
    logic [NUM_CH-1:0] w_pend_d;
    logic              w_sel_found;
    logic [1:0]        w_sel_ch;
    logic              w_done_now;

    assign w_req      = {SYNC_P3_REQ_i, SYNC_P2_REQ_i, SYNC_P1_REQ_i, SYNC_P0_REQ_i};
    assign w_edge     = w_req & ~r_req_d & reg_ch_en_i;
    assign w_elig     = r_pend & reg_ch_en_i;
    assign w_done_now = (r_state == ST_ACTIVE) && arb_xfer_done_i;

    // The granted/active channel keeps its pending bit even if its enable drops.
    assign w_active_mask = (r_state != ST_IDLE) ? (4'b0001 << r_grant_ch) : 4'b0000;
    assign w_done_mask   = w_done_now ? (4'b0001 << r_grant_ch) : 4'b0000;
    assign w_pend_d      = (r_pend & ~w_done_mask & ~(~reg_ch_en_i & ~w_active_mask)) | w_edge;

    always_comb begin
        logic [1:0] w_idx;
        w_sel_found = 1'b0;
        w_sel_ch    = 2'd0;
        w_idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = reg_prio_mode_i ? 2'(i) : (r_rr_ptr + 2'(i));
            if (!w_sel_found && w_elig[w_idx]) begin
                w_sel_found = 1'b1;
                w_sel_ch    = w_idx;
            end
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (axi_m_rst_i) begin
            r_state       <= ST_IDLE;
            r_req_d       <= '0;
            r_pend        <= '0;
            r_rr_ptr      <= 2'd0;
            r_grant_ch    <= 2'd0;
            r_grant_valid <= 1'b0;
        end else begin
            r_req_d <= w_req;
            r_pend  <= w_pend_d;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        r_grant_ch    <= w_sel_ch;
                        r_grant_valid <= 1'b1;
                        r_state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (arb_grant_ready_i) begin
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (arb_xfer_done_i) begin
                        r_rr_ptr <= r_grant_ch + 2'd1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb_grant_valid_o = r_grant_valid;
    assign arb_grant_ch_o    = r_grant_ch;
    assign arb_busy_o        = (r_state != ST_IDLE);
    assign arb_pend_o        = r_pend;

endmodule

// File: doc/dma_req_arbiter.md
# dma_req_arbiter

Arbitrates among the four synchronised peripheral DMA request lines (SYNC_P0..P3_REQ) in the ACLK domain and hands one channel at a time to the DMA engine. Each request rising edge is latched as a pending bit. Pending, enabled channels are chosen by round-robin or fixed priority. The granted channel is presented through a valid/ready handshake and held until the engine reports that the transfer is done.

## Interface
Parameters:
- NUM_CH, 4, number of peripheral channels; fixed at 4. The channel index is 2 bits wide.

Ports:
- ACLK_i  in  1  AXI master clock; the block's only clock.
- axi_m_rst_i  in  1  reset, synchronous to ACLK_i, active-high.
- SYNC_P0_REQ_i..SYNC_P3_REQ_i  in  1 each  peripheral request levels, already synchronised to ACLK_i.
- reg_ch_en_i  in  4  per-channel enable; bit n enables Pn.
- reg_prio_mode_i  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority with P0 highest.
- arb_grant_valid_o  out  1  a grant is offered to the engine.
- arb_grant_ch_o  out  2  index of the granted channel.
- arb_grant_ready_i  in  1  engine accepts the grant.
- arb_xfer_done_i  in  1  one-cycle pulse: the engine has finished the active channel.
- arb_busy_o  out  1  the state machine is not IDLE.
- arb_pend_o  out  4  pending bits.

## Operation
- Edge detect:
  - req_d[n] registers SYNC_Pn_REQ_i.
  - edge[n] = SYNC_Pn_REQ_i & ~req_d[n] & reg_ch_en_i[n].
- Pending bits:
  - pend[n] is set on edge[n].
  - pend[n] is cleared when arb_xfer_done_i completes channel n.
  - pend[n] is cleared when reg_ch_en_i[n] is low and n is not the active channel.
  - Set wins over clear in the same cycle.
- State machine: IDLE, GRANT, ACTIVE.
  - IDLE: if (pend & reg_ch_en_i) != 0, select a channel, register it into arb_grant_ch_o, assert arb_grant_valid_o and go to GRANT. Otherwise stay in IDLE.
  - GRANT: hold arb_grant_valid_o=1 and arb_grant_ch_o stable until arb_grant_ready_i=1. Enable or request changes do not withdraw the grant. When valid&ready is seen at a clock edge, deassert valid and go to ACTIVE.
  - ACTIVE: wait for arb_xfer_done_i. On done: clear pend[active], set rr_ptr = active+1 mod 4 (wrapping 3 to 0), go to IDLE.
- Selection:
  - Round-robin: the first n with pend[n]&reg_ch_en_i[n], searching from rr_ptr upward and wrapping.
  - Fixed: the lowest such n. rr_ptr is still updated in fixed mode.
- arb_xfer_done_i is ignored in IDLE and in GRANT.
- A new edge on the active channel while ACTIVE re-sets pend, including in the done cycle. The channel therefore becomes eligible again after IDLE.
- arb_busy_o = (state != IDLE).

## Timing
- Reset (axi_m_rst_i=1 at a rising edge):
  - state = IDLE, pend = 0, rr_ptr = 0, req_d = 0.
  - arb_grant_valid_o = 0, arb_grant_ch_o = 0, arb_busy_o = 0, arb_pend_o = 0.
  - Because req_d resets to 0, a request that is already high when reset releases counts as an edge.
- Reset asserted mid-operation (GRANT or ACTIVE) aborts immediately to the reset state. Pending bits are lost.
- Request to grant latency, from SYNC_Pn_REQ_i rising in cycle k with the channel enabled and the block idle:
  - pend[n]=1 in cycle k+1.
  - arb_grant_valid_o=1 in cycle k+2.
- Handshake: ready sampled high in cycle g gives valid=0 and busy=1 (ACTIVE) in cycle g+1. Ready may already be high when valid rises; transfer then happens at the first edge.
- Done pulse in cycle d: IDLE and pend cleared in cycle d+1; the next grant is valid in cycle d+2 at the earliest.
- Level requests held high generate no further pends; only rising edges count.

## Test plan
- Single request: reset, en=4'hF, raise P2 in cycle 10 → pend=4'b0100 in cycle 11; valid=1, ch=2 in cycle 12; ready in cycle 14 → valid=0, busy=1 in cycle 15; done in cycle 20 → pend=0, busy=0 in cycle 21.
- Round-robin fairness: all four requests edge together, ready tied high, a done 3 cycles after each accept → grant order 0,1,2,3. A second burst after that also gives 0,1,2,3, since rr_ptr has wrapped to 0.
- Fixed priority: mode=1, pend={P3,P1} → ch=1 first. P0 edges during ACTIVE → next grant is ch=0, then ch=3.
- Enable masking: en=4'b1110 and P0 edge → pend[0] stays 0 and no grant. en[3] dropped while P3 is pending and idle → pend[3] clears next cycle.
- Handshake stability: hold ready=0 for 10 cycles while P0 edges (ch=2 granted) → ch stays 2 and valid stays 1. Done pulsed during GRANT is ignored.
- Reset mid-transfer: assert reset in ACTIVE with pend=4'b1010 → next cycle all outputs 0. With P1 held high at release → pend[1]=1 one cycle after release.
